// File: rtl/scb_pkg.sv
// Shared constants and types for the SCB scratchpad arbiter.
package scb_pkg;

  localparam int SCB_A = 11;
  localparam int SCB_D = 16;
  localparam int SCB_B = 2;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_RESP = 1'b1
  } scb_state_e;

  typedef logic [0:0] scb_idx_t;

endpackage

// File: rtl/scb_arbiter_if.sv
// SCB arbiter bus bundle: both requester ports plus the scratchpad slave port.
// Modport slave is the arbiter's view; master is the fabric/scratchpad view.
interface scb_arbiter_if #(
  parameter int A = scb_pkg::SCB_A,
  parameter int D = scb_pkg::SCB_D,
  parameter int B = scb_pkg::SCB_B
);

  logic [A-1:0] m0_Addr_i;
  logic [D-1:0] m0_Data_i;
  logic [D-1:0] m0_Data_o;
  logic [B-1:0] m0_stb_i;
  logic         m0_ce_i;
  logic         m0_rd_i;
  logic         m0_wr_i;
  logic         m0_rdy_o;

  logic [A-1:0] m1_Addr_i;
  logic [D-1:0] m1_Data_i;
  logic [D-1:0] m1_Data_o;
  logic [B-1:0] m1_stb_i;
  logic         m1_ce_i;
  logic         m1_rd_i;
  logic         m1_wr_i;
  logic         m1_rdy_o;

  logic [A-1:0] scb_Addr_o;
  logic [D-1:0] scb_Data_o;
  logic [D-1:0] scb_Data_i;
  logic [B-1:0] scb_stb_o;
  logic         scb_ce_o;
  logic         scb_rd_o;
  logic         scb_wr_o;
  logic         scb_rdy_i;

  modport slave (
    input  m0_Addr_i, m0_Data_i, m0_stb_i, m0_ce_i, m0_rd_i, m0_wr_i,
    output m0_Data_o, m0_rdy_o,
    input  m1_Addr_i, m1_Data_i, m1_stb_i, m1_ce_i, m1_rd_i, m1_wr_i,
    output m1_Data_o, m1_rdy_o,
    output scb_Addr_o, scb_Data_o, scb_stb_o, scb_ce_o, scb_rd_o, scb_wr_o,
    input  scb_Data_i, scb_rdy_i
  );

  modport master (
    output m0_Addr_i, m0_Data_i, m0_stb_i, m0_ce_i, m0_rd_i, m0_wr_i,
    input  m0_Data_o, m0_rdy_o,
    output m1_Addr_i, m1_Data_i, m1_stb_i, m1_ce_i, m1_rd_i, m1_wr_i,
    input  m1_Data_o, m1_rdy_o,
    input  scb_Addr_o, scb_Data_o, scb_stb_o, scb_ce_o, scb_rd_o, scb_wr_o,
    output scb_Data_i, scb_rdy_i
  );

endinterface

// File: rtl/scb_arb_pick.sv
// Winner selection for the two SCB requesters.
// SCB_ARB_RR_EN defined: round-robin on ptr; undefined: fixed priority to m0.
module scb_arb_pick
  import scb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       ptr_nxt
);

`ifdef SCB_ARB_RR_EN
  // ptr=0 favours m0; after a grant the pointer favours the loser.
  always_comb begin
    gnt     = 2'b00;
    ptr_nxt = ptr;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    if (gnt[0]) begin
      ptr_nxt = 1'b1;
    end else if (gnt[1]) begin
      ptr_nxt = 1'b0;
    end else begin
      ptr_nxt = ptr;
    end
  end
`else
  // Pointer just recirculates its reset value, so the register folds away.
  always_comb begin
    gnt     = 2'b00;
    ptr_nxt = ptr;
    if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end else begin
      gnt = 2'b00;
    end
  end
`endif

endmodule

// File: rtl/scb_arbiter.sv
// Two-requester arbiter/sequencer for the SCB scratchpad slave port.
// Arbitration mode is chosen by SCB_ARB_RR_EN inside scb_arb_pick.
module scb_arbiter
  import scb_pkg::*;
#(
  parameter int A = SCB_A,
  parameter int D = SCB_D,
  parameter int B = SCB_B
) (
  input  logic         clk_i,
  input  logic         rst_i,
  scb_arbiter_if.slave bus
);

  localparam logic [0:0] ST_IDLE    = IDLE;
  localparam logic [0:0] ST_RD_RESP = RD_RESP;

  logic [0:0]   state_r;
  scb_idx_t     owner_r;
  logic         ptr_r;
  logic [A-1:0] addr_r;
  logic [B-1:0] stb_r;
  logic [D-1:0] rdata_r [2];

  logic [A-1:0] req_addr_s [2];
  logic [D-1:0] req_data_s [2];
  logic [B-1:0] req_stb_s  [2];
  logic [1:0]   req_s, req_rd_s, req_wr_s, gnt_s, rdy_s;
  scb_idx_t     win_s;
  logic         ptr_nxt_s, fwd_s, rd_go_s, rd_resp_s;
  logic [A-1:0] scb_addr_s;
  logic [D-1:0] scb_data_s;
  logic [B-1:0] scb_stb_s;
  logic         scb_ce_s, scb_rd_s, scb_wr_s;

  assign req_addr_s[0] = bus.m0_Addr_i;
  assign req_addr_s[1] = bus.m1_Addr_i;
  assign req_data_s[0] = bus.m0_Data_i;
  assign req_data_s[1] = bus.m1_Data_i;
  assign req_stb_s[0]  = bus.m0_stb_i;
  assign req_stb_s[1]  = bus.m1_stb_i;
  assign req_s         = {bus.m1_ce_i, bus.m0_ce_i};
  assign req_rd_s      = {bus.m1_rd_i, bus.m0_rd_i};
  assign req_wr_s      = {bus.m1_wr_i, bus.m0_wr_i};

  scb_arb_pick u_pick (
    .req     (req_s),
    .ptr     (ptr_r),
    .gnt     (gnt_s),
    .ptr_nxt (ptr_nxt_s)
  );

  assign win_s = scb_idx_t'(gnt_s[1]);

  // Forward the winner in IDLE, or complete the pending read in RD_RESP.
  always_comb begin
    scb_addr_s = addr_r;
    scb_data_s = {D{1'b0}};
    scb_stb_s  = stb_r;
    scb_ce_s   = 1'b0;
    scb_rd_s   = 1'b0;
    scb_wr_s   = 1'b0;
    rdy_s      = 2'b00;
    fwd_s      = 1'b0;
    rd_go_s    = 1'b0;
    if (rst_i) begin
      scb_addr_s = {A{1'b0}};
      scb_stb_s  = {B{1'b0}};
    end else if (state_r == ST_RD_RESP) begin
      rdy_s[owner_r] = 1'b1;
    end else if (|req_s) begin
      fwd_s      = 1'b1;
      scb_addr_s = req_addr_s[win_s];
      scb_data_s = req_data_s[win_s];
      scb_stb_s  = req_stb_s[win_s];
      // rd+wr together is treated as a write; neither is a bare acknowledge.
      if (req_wr_s[win_s]) begin
        scb_ce_s      = 1'b1;
        scb_wr_s      = 1'b1;
        rdy_s[win_s]  = bus.scb_rdy_i;
      end else if (req_rd_s[win_s]) begin
        scb_ce_s = 1'b1;
        scb_rd_s = 1'b1;
        rd_go_s  = bus.scb_rdy_i;
      end else begin
        rdy_s[win_s] = bus.scb_rdy_i;
      end
    end else begin
      scb_addr_s = addr_r;
    end
  end

  assign rd_resp_s = (state_r == ST_RD_RESP) && !rst_i;

  assign bus.scb_Addr_o = scb_addr_s;
  assign bus.scb_Data_o = scb_data_s;
  assign bus.scb_stb_o  = scb_stb_s;
  assign bus.scb_ce_o   = scb_ce_s;
  assign bus.scb_rd_o   = scb_rd_s;
  assign bus.scb_wr_o   = scb_wr_s;
  assign bus.m0_rdy_o   = rdy_s[0];
  assign bus.m1_rdy_o   = rdy_s[1];
  assign bus.m0_Data_o  = (rd_resp_s && owner_r == 1'b0) ? bus.scb_Data_i : rdata_r[0];
  assign bus.m1_Data_o  = (rd_resp_s && owner_r == 1'b1) ? bus.scb_Data_i : rdata_r[1];

  // Sequencer state, read owner and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      owner_r <= 1'b0;
      ptr_r   <= 1'b0;
    end else if (state_r == ST_RD_RESP) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= rd_go_s ? ST_RD_RESP : ST_IDLE;
      if (rd_go_s) begin
        owner_r <= win_s;
      end
      if (fwd_s && bus.scb_rdy_i) begin
        ptr_r <= ptr_nxt_s;
      end
    end
  end

  // Held address/strobe keep the scratchpad's byte steering valid between grants.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_r <= {A{1'b0}};
      stb_r  <= {B{1'b0}};
    end else if (fwd_s) begin
      addr_r <= scb_addr_s;
      stb_r  <= scb_stb_s;
    end
  end

  // Per-requester read data, held between reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_r[0] <= {D{1'b0}};
      rdata_r[1] <= {D{1'b0}};
    end else if (rd_resp_s) begin
      rdata_r[owner_r] <= bus.scb_Data_i;
    end
  end

endmodule

// File: doc/scb_arbiter.md
# scb_arbiter

Two-requester arbiter and sequencer in front of the 2 KiB SCB scratchpad. It shares the scratchpad's single SCB slave port between the CPU data port (m0) and the DMA engine (m1). It grants one access at a time and sequences the scratchpad's synchronous-read timing into a ready handshake for each requester. It sits between the core/DMA bus fabric and the scratchpad memory instance.

## Interface
Parameters:
- A, 11, byte address width
- D, 16, data width
- B, 2, byte-strobe width (bit1 = odd/high byte, bit0 = even/low byte)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- mN_Addr_i  in  A  requester N byte address (N = 0, 1)
- mN_Data_i  in  D  requester N write data
- mN_Data_o  out  D  requester N read data, valid when mN_rdy_o & read
- mN_stb_i  in  B  requester N byte strobes
- mN_ce_i  in  1  requester N request valid
- mN_rd_i  in  1  requester N read
- mN_wr_i  in  1  requester N write
- mN_rdy_o  out  1  requester N access complete (one-cycle pulse)
- scb_Addr_o  out  A  to scratchpad address
- scb_Data_o  out  D  to scratchpad write data
- scb_Data_i  in  D  from scratchpad read data
- scb_stb_o  out  B  to scratchpad strobes
- scb_ce_o, scb_rd_o, scb_wr_o  out  1 each  to scratchpad controls
- scb_rdy_i  in  1  scratchpad ready; tied high today, sampled anyway

## Operation
- **Requester contract.** A requester raises ce with exactly one of rd/wr. It holds Addr, Data, stb and rd/wr stable until the cycle its rdy_o is high. It may drop ce or present a new request the cycle after rdy.
- **States:** IDLE, RD_RESP.
- **IDLE, no requester has ce:** all scb_* controls are 0 and the address is held at its last value.
- **IDLE, one or more requests:** pick a winner, then forward the winner's Addr/Data/stb/rd/wr to scb_* with scb_ce_o=1.
  - Winner is writing: mN_rdy_o=1 in the same cycle (when scb_rdy_i=1). Stay in IDLE.
  - Winner is reading: register the owner and go to RD_RESP.
- **RD_RESP:**
  - scb_ce_o/rd_o/wr_o = 0. scb_Addr_o and scb_stb_o are held at the read's values so the scratchpad's byte/bank steering stays valid.
  - owner mN_Data_o = scb_Data_i and owner mN_rdy_o = 1. Return to IDLE.
  - No arbitration takes place in this cycle.
- **Illegal and degenerate requests:**
  - ce with both rd and wr: treated as a write.
  - ce with neither rd nor wr: acknowledged in one IDLE cycle with rdy, and scb_ce_o stays 0.
- **Write with stb=0:** forwarded unchanged; the memory writes nothing.
- **mN_Data_o while not ready:** holds its last read value. It resets to 0.
- **Non-winner:** rdy_o=0. Its request stays pending.
- **Pointer update:** the round-robin pointer updates only on a grant, to favour the requester that did not win.
- **scb_rdy_i=0 in IDLE:** the grant is still driven, but rdy is withheld and the state and pointer are unchanged, so the request re-presents next cycle. In RD_RESP, rdy_i is ignored.

## Timing
- **Write latency:** 0 cycles; rdy is in the request cycle.
- **Read latency:** 1 cycle; rdy and data arrive the cycle after the grant.
- **Throughput:** 1 write/cycle; 1 read per 2 cycles.
- **Reset values:** state IDLE; pointer favours m0; mN_rdy_o=0; mN_Data_o=0; scb_ce_o/rd_o/wr_o=0; scb_Addr_o=0; scb_stb_o=0; scb_Data_o=0.
- **Reset asserted in RD_RESP:** the read is abandoned. No rdy is issued and the owner must re-request.
- **Both requesting continuously:** grants alternate m0, m1, m0, … with no requester starved longer than one access.
- All scb_* outputs are combinational from the inputs and state. The only registers are state, owner, pointer, the held addr/stb, and the per-requester read data.

## Configuration
- **SCB_ARB_RR_EN defined:** round-robin arbitration as described.
- **SCB_ARB_RR_EN undefined:** fixed priority, where m0 always wins a simultaneous request. The pointer register is removed, and m1 may be starved by back-to-back m0 traffic.

## Structure
- **Shared package scb_pkg:**
  - constants SCB_A=11, SCB_D=16, SCB_B=2
  - state enum {IDLE, RD_RESP}
  - requester index type (1 bit)
- **Sub-module scb_arb_pick:**
  - inputs: two request bits and the pointer
  - outputs: one-hot grant and the next pointer
  - it holds the SCB_ARB_RR_EN ifdef, isolating it from the sequencer.

## Test plan
- **Reset then idle:** rst_i high for 2 cycles, no requests -> all outputs 0 and state IDLE.
- **Single write then read:**
  - m0 writes 0xBEEF to 0x012 with stb=2'b11 -> m0_rdy_o=1 the same cycle.
  - m0 then reads 0x012 -> m0_rdy_o=1 one cycle later with m0_Data_o=0xBEEF, and scb_ce_o=0 in that cycle.
- **Byte write, high bank:** write 0x1234 to 0x402 with stb=2'b10, then read -> data high byte 0x12, low byte unchanged from prior contents.
- **Contention:** m0 and m1 both read continuously from 0x000 and 0x400 -> grants alternate m0, m1, m0 (rdy every 2 cycles, alternating owners). With SCB_ARB_RR_EN undefined, m1 never gets rdy.
- **Mid-read reset:** m1 read granted, rst_i asserted in RD_RESP -> m1_rdy_o stays 0 and the state is IDLE next cycle.
- **Degenerate requests:**
  - m0 ce with rd=wr=0 -> m0_rdy_o=1 the same cycle and scb_ce_o=0.
  - m1 ce with rd=wr=1 -> scb_wr_o=1 and scb_rd_o=0.
